// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU request issuer: operation encodings, flag
// bit positions, the request/response structs, the issuer FSM state type and
// the golden ALU function used by the optional result checker.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Bit positions inside the 5-bit flag vector {parity, overflow, greater, less, is_eq}
  localparam int FLAG_W        = 5;
  localparam int FLAG_PARITY   = 4;
  localparam int FLAG_OVERFLOW = 3;
  localparam int FLAG_GREATER  = 2;
  localparam int FLAG_LESS     = 1;
  localparam int FLAG_IS_EQ    = 0;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_req_t;

  typedef struct packed {
    logic [7:0]        y;
    logic [FLAG_W-1:0] flags;
  } alu_rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } issue_state_t;

  // Golden ALU: 8-bit truncated result, even-parity-of-y, signed overflow
  // for add/sub only, and an unsigned compare of the operands.
  function automatic alu_rsp_t alu_ref(input alu_req_t req);
    alu_rsp_t   rsp;
    logic [7:0] y;
    logic       ovf;
    y   = '0;
    ovf = 1'b0;
    case (req.op)
      OP_ADD: begin
        y   = req.a + req.b;
        ovf = (req.a[7] == req.b[7]) && (y[7] != req.a[7]);
      end
      OP_SUB: begin
        y   = req.a - req.b;
        ovf = (req.a[7] != req.b[7]) && (y[7] != req.a[7]);
      end
      OP_AND:  y = req.a & req.b;
      default: y = req.a ^ req.b;
    endcase
    rsp.y                     = y;
    rsp.flags                 = '0;
    rsp.flags[FLAG_PARITY]    = ^y;
    rsp.flags[FLAG_OVERFLOW]  = ovf;
    rsp.flags[FLAG_GREATER]   = req.a > req.b;
    rsp.flags[FLAG_LESS]      = req.a < req.b;
    rsp.flags[FLAG_IS_EQ]     = req.a == req.b;
    return rsp;
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// alu_req_fifo
// Request buffer for the ALU issuer. DEPTH entries (power of two, >= 2) of
// type T. Pointers carry one extra wrap bit so full and empty are told apart
// without a separate counter. Push and pop in the same cycle are both taken.
// Callers never push when full or pop when empty.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   i_push        write i_pushData at the tail
//   i_pushData    entry to write
//   i_pop         drop the head entry
//   o_headData    current head entry (valid while !o_empty)
//   o_full        all DEPTH entries occupied
//   o_empty       no entries
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  T     i_pushData,
  input  logic i_pop,
  output T     o_headData,
  output logic o_full,
  output logic o_empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  T                 r_mem [DEPTH];

  // Pointer update; reset flushes the buffer by collapsing both pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (i_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wrPtr[ADDR_W-1:0]] <= i_pushData;
  end

  assign o_headData = r_mem[r_rdPtr[ADDR_W-1:0]];
  assign o_empty    = (r_wrPtr == r_rdPtr);
  // Same slot but different lap means the writer is a full lap ahead.
  assign o_full     = (r_wrPtr[ADDR_W] != r_rdPtr[ADDR_W]) &&
                      (r_wrPtr[ADDR_W-1:0] == r_rdPtr[ADDR_W-1:0]);

endmodule

// File: rtl/alu_req_issuer.sv
// alu_req_issuer
// Request-side front end for the 8-bit ALU. Requests are queued in a small
// FIFO, then issued one at a time: operands are loaded onto alu_op/a/b and
// held for LAT cycles, after which alu_y and the flags are captured into a
// response held until the consumer accepts it. Responses leave in request
// order.
//
// Optional feature macro: ALU_REQ_CHECK_EN adds a golden model and the
// 'mismatch' output, pulsed alongside the rising rsp_valid when the captured
// result differs from the model.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (req_ready = FIFO not full)
//   req_op, req_a, req_b      requested operation and operands
//   alu_op, alu_a, alu_b      operands driven to the ALU (registered)
//   alu_y, alu_*flags         ALU result inputs
//   rsp_valid/rsp_ready       response handshake
//   rsp_y, rsp_flags          captured result, flags {par, ovf, gt, lt, eq}
//   busy                      FIFO non-empty or FSM not idle
//   mismatch                  checker result (ALU_REQ_CHECK_EN only)
module alu_req_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [7:0]        req_a,
  input  logic [7:0]        req_b,
  output logic [1:0]        alu_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_y,
  input  logic              alu_parity,
  input  logic              alu_overflow,
  input  logic              alu_greater,
  input  logic              alu_less,
  input  logic              alu_is_eq,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_y,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic              busy
`ifdef ALU_REQ_CHECK_EN
  ,
  output logic              mismatch
`endif
);

  localparam logic [2:0] CNT_LAST = 3'(LAT - 1);

  issue_state_t      r_state;
  logic [2:0]        r_cnt;
  alu_req_t          w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [FLAG_W-1:0] w_aluFlags;

  assign w_push     = req_valid && !w_full;
  // The head is consumed exactly when the FSM loads new operands: from IDLE,
  // or from RESP in the same cycle the held response is accepted.
  assign w_pop      = !w_empty &&
                      ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));
  assign w_aluFlags = {alu_parity, alu_overflow, alu_greater, alu_less, alu_is_eq};

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .T     (alu_req_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pushData ({req_op, req_a, req_b}),
    .i_pop      (w_pop),
    .o_headData (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

`ifdef ALU_REQ_CHECK_EN
  alu_rsp_t w_expected;
  assign w_expected = alu_ref({alu_op, alu_a, alu_b});
`endif

  // Issue FSM. alu_* only change on a load, so the ALU sees stable operands
  // for the whole EXEC period; the result is sampled on the LAT-th edge after
  // the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_flags <= '0;
`ifdef ALU_REQ_CHECK_EN
      mismatch  <= 1'b0;
`endif
    end else begin
`ifdef ALU_REQ_CHECK_EN
      mismatch <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            alu_op  <= w_head.op;
            alu_a   <= w_head.a;
            alu_b   <= w_head.b;
            r_cnt   <= '0;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == CNT_LAST) begin
            rsp_y     <= alu_y;
            rsp_flags <= w_aluFlags;
            rsp_valid <= 1'b1;
            r_state   <= ST_RESP;
`ifdef ALU_REQ_CHECK_EN
            mismatch  <= ({alu_y, w_aluFlags} != w_expected);
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (!w_empty) begin
              alu_op  <= w_head.op;
              alu_a   <= w_head.a;
              alu_b   <= w_head.b;
              r_cnt   <= '0;
              r_state <= ST_EXEC;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = !w_full;
  assign busy      = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_req_issuer.sv
// tb_alu_req_issuer
// Bench for alu_req_issuer with DEPTH=4, LAT=3. A behavioural ALU with a
// LAT-cycle pipeline answers the issuer. Every accepted request pushes its
// expected response (computed with plain integer arithmetic) into a queue;
// an independent monitor pops and compares on every response handshake.
module tb_alu_req_issuer;

  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  typedef struct {
    logic [7:0] y;
    logic [4:0] flags;
    bit         mis;
  } expect_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] aluY;
  logic       aluParity, aluOverflow, aluGreater, aluLess, aluIsEq;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic [4:0] rsp_flags;
  logic       busy;
`ifdef ALU_REQ_CHECK_EN
  logic       mismatch;
`endif

  int         total = 0;
  int         bad = 0;
  int         cycleCount = 0;
  bit         spacingOn = 0;
  bit         corruptEn = 0;
  expect_t    expQ[$];
  logic [12:0] aluStage0, aluStage1;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  alu_req_issuer #(
    .DEPTH (DEPTH),
    .LAT   (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_y        (aluY),
    .alu_parity   (aluParity),
    .alu_overflow (aluOverflow),
    .alu_greater  (aluGreater),
    .alu_less     (aluLess),
    .alu_is_eq    (aluIsEq),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_y        (rsp_y),
    .rsp_flags    (rsp_flags),
    .busy         (busy)
`ifdef ALU_REQ_CHECK_EN
    ,
    .mismatch     (mismatch)
`endif
  );

  // Reference arithmetic on plain integers: returns {y, parity, ovf, gt, lt, eq}.
  function automatic logic [12:0] refModel(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    int         ia, ib, sa, sb, full, sfull;
    logic [7:0] y;
    bit         ovf;
    ia  = int'(a);
    ib  = int'(b);
    sa  = (ia > 127) ? ia - 256 : ia;
    sb  = (ib > 127) ? ib - 256 : ib;
    ovf = 1'b0;
    case (op)
      2'd0: begin
        full  = ia + ib;
        sfull = sa + sb;
        ovf   = (sfull > 127) || (sfull < -128);
      end
      2'd1: begin
        full  = ia - ib;
        sfull = sa - sb;
        ovf   = (sfull > 127) || (sfull < -128);
      end
      2'd2:    full = ia & ib;
      default: full = ia ^ ib;
    endcase
    y = full[7:0];
    return {y, ^y, ovf, ia > ib, ia < ib, ia == ib};
  endfunction

  // ALU stand-in, optionally corrupting y bit 0 for xor 0xAA^0x55.
  function automatic logic [12:0] aluOut(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [12:0] r;
    r = refModel(op, a, b);
    if (corruptEn && op == 2'd3 && a == 8'hAA && b == 8'h55) r[5] = ~r[5];
    return r;
  endfunction

  // Two register stages: the result of operands loaded at edge E appears
  // after edge E+2 and is therefore valid when sampled at edge E+LAT (LAT=3).
  always @(posedge clk) begin
    aluStage0 <= aluOut(alu_op, alu_a, alu_b);
    aluStage1 <= aluStage0;
  end
  assign {aluY, aluParity, aluOverflow, aluGreater, aluLess, aluIsEq} = aluStage1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One cycle of stimulus, driven on the falling edge. An accepted request
  // pushes its expected response.
  task automatic applyStimulus(input bit valid, input logic [1:0] op, input logic [7:0] a,
                               input logic [7:0] b, input bit rReady, input bit corruptExp,
                               output bit accepted);
    expect_t     e;
    logic [12:0] r;
    @(negedge clk);
    req_valid = valid;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = rReady;
    accepted  = valid && req_ready;
    if (accepted) begin
      r       = refModel(op, a, b);
      e.y     = r[12:5];
      e.flags = r[4:0];
      e.mis   = 1'b0;
      if (corruptExp) begin
        e.y[0] = ~e.y[0];
        e.mis  = 1'b1;
      end
      expQ.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    bit acc;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 1'b0, acc);
      n++;
    end
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: %0d responses still pending, required 0", expQ.size());
      expQ.delete();
    end
    repeat (2) applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 1'b0, acc);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_req_ready", req_ready, 1);
  endtask

  function automatic logic [7:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'h7F;
      2:       return 8'h80;
      3:       return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Monitor: operand stability, optional mismatch pulse, and in-order
  // response checking on each handshake.
  always begin : monitor
    expect_t     e;
    bit          prevValid;
    bit          havePrev;
    int          lastCycle;
    int          stableCnt;
    logic [17:0] prevOps;
    bit          expMis;
    @(negedge clk);
    #1;
    if (!spacingOn) havePrev = 1'b0;
    if (rst) begin
      prevValid = 1'b0;
      stableCnt = 0;
      prevOps   = {alu_op, alu_a, alu_b};
    end else begin
      if ({alu_op, alu_a, alu_b} == prevOps) stableCnt++;
      else stableCnt = 0;
      prevOps = {alu_op, alu_a, alu_b};
`ifdef ALU_REQ_CHECK_EN
      expMis = (rsp_valid && !prevValid && expQ.size() > 0) ? expQ[0].mis : 1'b0;
      checkOutput("mismatch", mismatch, expMis);
`else
      expMis = 1'b0;
`endif
      if (rsp_valid && !prevValid) begin
        total++;
        if (stableCnt < LAT) begin
          bad++;
          $display("[TB] FAIL operand_stable: held %0d cycles, required >= %0d", stableCnt, LAT);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_rsp: got y=0x%0h with no request outstanding", rsp_y);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_y", rsp_y, e.y);
          checkOutput("rsp_flags", rsp_flags, e.flags);
          if (spacingOn) begin
            if (havePrev) checkOutput("rsp_spacing", cycleCount - lastCycle, LAT + 1);
            havePrev  = 1'b1;
            lastCycle = cycleCount;
          end
        end
      end
      prevValid = rsp_valid;
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    bit acc;
    int cyc;
    int accCount;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset then idle
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_alu_op", alu_op, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_rsp_y", rsp_y, 0);
    checkOutput("rst_rsp_flags", rsp_flags, 0);
`ifdef ALU_REQ_CHECK_EN
    checkOutput("rst_mismatch", mismatch, 0);
`endif

    // Single add 0x7F+0x01: accepted at edge E0, response visible after
    // edge E0+LAT+1, i.e. LAT+2 falling edges after the driving one.
    applyStimulus(1'b1, 2'd0, 8'h7F, 8'h01, 1'b1, 1'b0, acc);
    checkOutput("first_accept", acc, 1);
    cyc = 0;
    do begin
      applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 1'b0, acc);
      cyc++;
    end while (!rsp_valid && cyc < 20);
    checkOutput("latency", cyc, LAT + 2);
    checkOutput("add_7f_01_y", rsp_y, 8'h80);
    checkOutput("add_7f_01_flags", rsp_flags, 5'b11100);
    drain(50);

    // Back-pressure: with rsp_ready low the FIFO plus the held response
    // absorb DEPTH+1 requests, then req_ready drops.
    accCount = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 2'($urandom_range(0, 3)), pickOperand(), pickOperand(), 1'b0,
                    1'b0, acc);
      if (acc) accCount++;
    end
    checkOutput("stall_count", accCount, DEPTH + 1);
    checkOutput("stall_req_ready", req_ready, 0);
    drain(100);

    // Back-to-back subtracts with rsp_ready high: LAT+1 cycles apart.
    spacingOn = 1'b1;
    accCount  = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'd1, pickOperand(), pickOperand(), 1'b1, 1'b0, acc);
      if (acc) accCount++;
    end
    checkOutput("b2b_accepts", accCount, 4);
    drain(100);
    spacingOn = 1'b0;

    // Reset while in EXEC with two requests queued behind it.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 2'd2, pickOperand(), pickOperand(), 1'b1, 1'b0, acc);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_req_ready", req_ready, 1);
    rst = 1'b0;
    applyStimulus(1'b1, 2'd3, 8'h3C, 8'h0F, 1'b1, 1'b0, acc);
    checkOutput("postrst_accept", acc, 1);
    drain(50);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 250; i++)
      applyStimulus($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)), pickOperand(),
                    pickOperand(), $urandom_range(0, 99) < 70, 1'b0, acc);
    drain(600);

`ifdef ALU_REQ_CHECK_EN
    // Two good ops then a corrupted xor: only the xor raises mismatch.
    corruptEn = 1'b1;
    applyStimulus(1'b1, 2'd0, 8'h10, 8'h20, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 2'd1, 8'h05, 8'h09, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 2'd3, 8'hAA, 8'h55, 1'b1, 1'b1, acc);
    drain(100);
    corruptEn = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
